// File: rtl/cnn_pkg.sv
// Shared widths, index types and small helpers for the CNN output packer.
package cnn_pkg;

   localparam int WORD_W         = 64;
   localparam int BEAT_W         = 512;
   localparam int WORDS_PER_BEAT = 8;
   localparam int LANE_W         = 16;
   localparam int LANES_PER_WORD = WORD_W / LANE_W;
   localparam int ACC_WORDS      = WORDS_PER_BEAT - 1;
   localparam int SLOT_W         = $clog2(WORDS_PER_BEAT);
   localparam int WORD_IDX_W     = 12;
   localparam int IMG_CNT_W      = 8;

   typedef logic [WORD_W-1:0]     word_t;
   typedef logic [BEAT_W-1:0]     beat_t;
   typedef logic [LANE_W-1:0]     lane_t;
   typedef logic [1:0]            lane_idx_t;
   typedef logic [SLOT_W-1:0]     slot_idx_t;
   typedef logic [WORD_IDX_W-1:0] word_idx_t;

   // True when the given slot is the highest slot of a beat.
   function automatic logic is_final_slot(input slot_idx_t slot);
      return slot == slot_idx_t'(WORDS_PER_BEAT - 1);
   endfunction

endpackage

// File: rtl/cnn_beat_reg.sv
// Single 512-bit output register: loads a closed beat, holds it while the
// consumer stalls, and empties when the consumer takes it.
module cnn_beat_reg
   import cnn_pkg::*;
(
   input  logic              clk,
   input  logic              sync_rst_n,
   input  logic              load,
   input  logic [BEAT_W-1:0] load_bits,
   input  logic              load_last,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [BEAT_W-1:0] out_bits,
   output logic              out_last
);

   logic              valid_reg;
   logic              last_reg;
   logic [BEAT_W-1:0] bits_reg;

   // Load has priority; the top only loads when the register is empty or
   // being drained this cycle, so a stalled beat is never overwritten.
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
         bits_reg  <= '0;
      end else if (load) begin
         valid_reg <= 1'b1;
         last_reg  <= load_last;
         bits_reg  <= load_bits;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
      end
   end

   assign out_valid = valid_reg;
   assign out_bits  = bits_reg;
   assign out_last  = last_reg;

endmodule

// File: rtl/cnn_out_packer.sv
// Packs 64-bit CNN output words into 512-bit beats, closing a beat early at
// the end of each image and zero-filling the unused upper slots.
module cnn_out_packer
   import cnn_pkg::*;
#(
   parameter int WORDS_PER_IMG = 16
)
(
   input  logic                 clk,
   input  logic                 sync_rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_W-1:0]    in_bits,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BEAT_W-1:0]    out_bits,
   output logic                 out_last,
   output logic [IMG_CNT_W-1:0] img_cnt
);

   localparam word_idx_t LAST_WORD = word_idx_t'(WORDS_PER_IMG - 1);

   word_t                acc_reg [ACC_WORDS];
   slot_idx_t            slot_reg;
   word_idx_t            word_reg;
   logic [IMG_CNT_W-1:0] img_cnt_reg;

   logic                 img_end;
   logic                 beat_close;
   logic                 stall;
   logic                 accept;
   logic                 load;
   logic [BEAT_W-1:0]    beat_next;

   // A beat closes on the eighth slot or on the image's final word.
   assign img_end    = (word_reg == LAST_WORD);
   assign beat_close = is_final_slot(slot_reg) || img_end;

   // Only a closing word needs the output register; everything else can
   // always be absorbed by the accumulator.
   assign stall    = beat_close && out_valid && !out_ready;
   assign in_ready = sync_rst_n && !stall;
   assign accept   = in_valid && in_ready;
   assign load     = accept && beat_close;

   // Assemble the closing beat: stored words below the current slot, the
   // incoming word at the current slot, zeros above.
   for (genvar gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_slot
      if (gi < ACC_WORDS) begin : g_acc
         assign beat_next[gi*WORD_W +: WORD_W] =
            (slot_idx_t'(gi) <  slot_reg) ? acc_reg[gi] :
            (slot_idx_t'(gi) == slot_reg) ? in_bits     : '0;
      end else begin : g_top
         assign beat_next[gi*WORD_W +: WORD_W] =
            (slot_idx_t'(gi) == slot_reg) ? in_bits : '0;
      end
   end

   // Accumulator: store non-closing words in their slot.
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         for (int i = 0; i < ACC_WORDS; i++) begin
            acc_reg[i] <= '0;
         end
      end else if (accept && !beat_close) begin
         for (int i = 0; i < ACC_WORDS; i++) begin
            if (slot_reg == slot_idx_t'(i)) begin
               acc_reg[i] <= in_bits;
            end
         end
      end
   end

   // Slot and word-in-image counters; both restart at image end.
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         slot_reg <= '0;
         word_reg <= '0;
      end else if (accept) begin
         slot_reg <= beat_close ? '0 : slot_reg + 1'b1;
         word_reg <= img_end    ? '0 : word_reg + 1'b1;
      end
   end

   // Completed-image counter, bumped when the last beat is handed off.
   always_ff @(posedge clk) begin
      if (!sync_rst_n) begin
         img_cnt_reg <= '0;
      end else if (out_valid && out_ready && out_last) begin
         img_cnt_reg <= img_cnt_reg + 1'b1;
      end
   end

   assign img_cnt = img_cnt_reg;

   cnn_beat_reg u_beat_reg (
      .clk        (clk),
      .sync_rst_n (sync_rst_n),
      .load       (load),
      .load_bits  (beat_next),
      .load_last  (img_end),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_bits   (out_bits),
      .out_last   (out_last)
   );

endmodule

// File: tb/tb_cnn_out_packer.sv
// Bench for cnn_out_packer: three instances (16, 10 and 1 words per image),
// one active at a time, with a reference packing model feeding a scoreboard.
module tb_cnn_out_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n_d    = 1'b0;
   logic          in_valid_d = 1'b0;
   logic [63:0]   in_bits_d  = '0;
   logic          out_ready_d = 1'b1;
   int            cur = 0;

   logic          in_ready0, in_ready1, in_ready2;
   logic          out_valid0, out_valid1, out_valid2;
   logic [511:0]  out_bits0, out_bits1, out_bits2;
   logic          out_last0, out_last1, out_last2;
   logic [7:0]    img_cnt0, img_cnt1, img_cnt2;

   logic          in_ready_m, out_valid_m, out_last_m;
   logic [511:0]  out_bits_m;
   logic [7:0]    img_cnt_m;

   cnn_out_packer #(.WORDS_PER_IMG(16)) u_dut16 (
      .clk(clk), .sync_rst_n(rst_n_d),
      .in_valid(in_valid_d && (cur == 0)), .in_ready(in_ready0), .in_bits(in_bits_d),
      .out_valid(out_valid0), .out_ready(out_ready_d || (cur != 0)),
      .out_bits(out_bits0), .out_last(out_last0), .img_cnt(img_cnt0));

   cnn_out_packer #(.WORDS_PER_IMG(10)) u_dut10 (
      .clk(clk), .sync_rst_n(rst_n_d),
      .in_valid(in_valid_d && (cur == 1)), .in_ready(in_ready1), .in_bits(in_bits_d),
      .out_valid(out_valid1), .out_ready(out_ready_d || (cur != 1)),
      .out_bits(out_bits1), .out_last(out_last1), .img_cnt(img_cnt1));

   cnn_out_packer #(.WORDS_PER_IMG(1)) u_dut1 (
      .clk(clk), .sync_rst_n(rst_n_d),
      .in_valid(in_valid_d && (cur == 2)), .in_ready(in_ready2), .in_bits(in_bits_d),
      .out_valid(out_valid2), .out_ready(out_ready_d || (cur != 2)),
      .out_bits(out_bits2), .out_last(out_last2), .img_cnt(img_cnt2));

   assign in_ready_m  = (cur == 0) ? in_ready0  : (cur == 1) ? in_ready1  : in_ready2;
   assign out_valid_m = (cur == 0) ? out_valid0 : (cur == 1) ? out_valid1 : out_valid2;
   assign out_bits_m  = (cur == 0) ? out_bits0  : (cur == 1) ? out_bits1  : out_bits2;
   assign out_last_m  = (cur == 0) ? out_last0  : (cur == 1) ? out_last1  : out_last2;
   assign img_cnt_m   = (cur == 0) ? img_cnt0   : (cur == 1) ? img_cnt1   : img_cnt2;

   int total = 0;
   int bad   = 0;

   function automatic int wpi_of(input int idx);
      case (idx)
         0:       return 16;
         1:       return 10;
         default: return 1;
      endcase
   endfunction

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_beat(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model and scoreboard.
   logic [512:0] exp_q [$];
   logic [511:0] m_beat = '0;
   int           m_slot = 0;
   int           m_word = 0;
   logic         m_img_end;
   logic [512:0] m_exp;
   logic [512:0] held = '0;
   logic         holding = 1'b0;
   int           unstable = 0;
   int           beats_out = 0;

   // Sample handshakes mid-cycle; a handshake seen here transfers on the next rising edge.
   always @(negedge clk) begin
      if (!rst_n_d) begin
         m_beat = '0;
         m_slot = 0;
         m_word = 0;
         exp_q.delete();
         holding = 1'b0;
      end else begin
         if (in_valid_d && in_ready_m) begin
            m_beat[m_slot*64 +: 64] = in_bits_d;
            m_img_end = (m_word == wpi_of(cur) - 1);
            if (m_slot == 7 || m_img_end) begin
               exp_q.push_back({m_img_end, m_beat});
               m_beat = '0;
               m_slot = 0;
            end else begin
               m_slot++;
            end
            m_word = m_img_end ? 0 : m_word + 1;
         end
         if (out_valid_m && !out_ready_d) begin
            if (holding && ({out_last_m, out_bits_m} !== held)) unstable++;
            held = {out_last_m, out_bits_m};
            holding = 1'b1;
         end else begin
            holding = 1'b0;
         end
         if (out_valid_m && out_ready_d) begin
            beats_out++;
            if (exp_q.size() == 0) begin
               chk_int("unexpected_beat", 1, 0);
            end else begin
               m_exp = exp_q.pop_front();
               chk_beat("beat_bits", out_bits_m, m_exp[511:0]);
               chk_int("beat_last", int'(out_last_m), int'(m_exp[512]));
            end
         end
      end
   end

   int drops = 0;
   int first_drop = -1;

   // mode 0: in_valid=1, data=base+k, out_ready low for the first 'stall' cycles.
   // mode 1: random in_valid/out_ready, random data.
   task automatic run(input int n, input int mode, input int stall,
                      input logic [63:0] base, output int cycles);
      int acc = 0;
      int cyc = 0;
      int limit = n * 10 + 100;
      while (acc < n && cyc < limit) begin
         @(posedge clk); #1;
         if (mode == 0) begin
            in_valid_d  = 1'b1;
            in_bits_d   = base + 64'(acc);
            out_ready_d = (cyc >= stall);
         end else begin
            in_valid_d  = 1'($urandom_range(0, 1));
            in_bits_d   = {$urandom, $urandom};
            out_ready_d = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (in_valid_d && !in_ready_m) begin
            drops++;
            if (first_drop < 0) first_drop = acc;
         end
         if (in_valid_d && in_ready_m) acc++;
         cyc++;
      end
      if (acc < n) chk_int("run_timeout_words", acc, n);
      cycles = cyc;
   endtask

   task automatic drain();
      int n = 0;
      @(posedge clk); #1;
      in_valid_d  = 1'b0;
      out_ready_d = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || out_valid_m) && n < 200);
      chk_int("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n_d    = 1'b0;
      in_valid_d = 1'b0;
      out_ready_d = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n_d = 1'b1;
      beats_out  = 0;
      drops      = 0;
      first_drop = -1;
      unstable   = 0;
   endtask

   typedef struct {
      logic        vld;
      logic [63:0] bits;
      logic        rdy;
      logic        e_in_ready;
      logic        e_out_valid;
      logic        e_out_last;
      int          e_img;
   } vec_t;

   vec_t tbl [14];
   int   cycles;

   initial begin
      // Cycle table for 10 words/image, words 1..10, beat1 stalled two cycles.
      for (int r = 0; r < 14; r++) begin
         tbl[r].vld         = (r < 10);
         tbl[r].bits        = (r < 10) ? 64'(r + 1) : 64'hdead_beef_0000_0000;
         tbl[r].rdy         = !(r == 10 || r == 11);
         tbl[r].e_in_ready  = 1'b1;
         tbl[r].e_out_valid = (r == 8) || (r >= 10 && r <= 12);
         tbl[r].e_out_last  = (r >= 10 && r <= 12);
         tbl[r].e_img       = (r == 13) ? 1 : 0;
      end

      // Reset state.
      cur = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_int("rst_in_ready", int'(in_ready0), 0);
      chk_int("rst_out_valid", int'(out_valid0), 0);
      chk_int("rst_out_last", int'(out_last0), 0);
      chk_int("rst_img_cnt", int'(img_cnt0), 0);
      chk_int("rst_out_valid_w1", int'(out_valid2), 0);
      @(posedge clk); #1 rst_n_d = 1'b1;
      @(negedge clk);
      chk_int("post_rst_in_ready", int'(in_ready0), 1);

      // 16 words 0..15 straight through: two beats, one image.
      do_reset();
      run(16, 0, 0, 64'd0, cycles);
      chk_int("img16_drops", drops, 0);
      chk_int("img16_cycles", cycles, 16);
      drain();
      chk_int("img16_beats", beats_out, 2);
      chk_int("img16_img_cnt", int'(img_cnt_m), 1);

      // Table-driven, 10 words/image.
      cur = 1;
      do_reset();
      for (int r = 0; r < 14; r++) begin
         @(posedge clk); #1;
         in_valid_d  = tbl[r].vld;
         in_bits_d   = tbl[r].bits;
         out_ready_d = tbl[r].rdy;
         @(negedge clk);
         chk_int($sformatf("tbl%0d_in_ready", r), int'(in_ready_m), int'(tbl[r].e_in_ready));
         chk_int($sformatf("tbl%0d_out_valid", r), int'(out_valid_m), int'(tbl[r].e_out_valid));
         if (tbl[r].e_out_valid)
            chk_int($sformatf("tbl%0d_out_last", r), int'(out_last_m), int'(tbl[r].e_out_last));
         chk_int($sformatf("tbl%0d_img_cnt", r), int'(img_cnt_m), tbl[r].e_img);
      end
      drain();
      chk_int("tbl_beats", beats_out, 2);

      // Output stall of 20 cycles under continuous input.
      cur = 0;
      do_reset();
      run(48, 0, 20, 64'h1000, cycles);
      chk_int("stall_first_drop_words", first_drop, 15);
      drain();
      chk_int("stall_unstable", unstable, 0);
      chk_int("stall_beats", beats_out, 6);
      chk_int("stall_img_cnt", int'(img_cnt_m), 3);

      // Reset with a pending beat and a partial beat; then a fresh image.
      do_reset();
      run(13, 0, 1000, 64'h100, cycles);
      chk_int("pend_out_valid", int'(out_valid_m), 1);
      @(posedge clk); #1;
      rst_n_d = 1'b0;
      in_valid_d = 1'b0;
      @(posedge clk); #1;
      rst_n_d = 1'b1;
      out_ready_d = 1'b1;
      beats_out = 0;
      @(negedge clk);
      chk_int("midrst_out_valid", int'(out_valid_m), 0);
      chk_int("midrst_img_cnt", int'(img_cnt_m), 0);
      run(8, 0, 0, 64'h200, cycles);
      drain();
      chk_int("midrst_first_beats", beats_out, 1);
      chk_int("midrst_img_before_last", int'(img_cnt_m), 0);
      run(8, 0, 0, 64'h208, cycles);
      drain();
      chk_int("midrst_img_after_last", int'(img_cnt_m), 1);

      // One word per image: one beat per cycle, every beat last.
      cur = 2;
      do_reset();
      run(20, 0, 0, 64'h1, cycles);
      chk_int("w1_cycles", cycles, 20);
      chk_int("w1_drops", drops, 0);
      drain();
      chk_int("w1_beats", beats_out, 20);
      chk_int("w1_img_cnt", int'(img_cnt_m), 20);

      // Random traffic, 300 images of 16 words.
      cur = 0;
      do_reset();
      run(300 * 16, 1, 0, 64'd0, cycles);
      drain();
      chk_int("rand_beats", beats_out, 600);
      chk_int("rand_img_cnt", int'(img_cnt_m), 44);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
